// File: rtl/rx_buffer_ctrl.sv
// Receive-buffer sequencer: pointers, occupancy and status for a single-port RX buffer.
// Optional threshold interrupt enabled by defining RXC_THRESH_EN (adds the thresh port).
module rx_buffer_ctrl #(
  parameter int DEPTH    = 4,
  parameter int AW       = 2,
  parameter int BITWIDTH = 8
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                rx_valid,
  input  logic                rd_req,
  input  logic                ovr_clr,
  input  logic [BITWIDTH-1:0] buf_dout,
`ifdef RXC_THRESH_EN
  input  logic [AW:0]         thresh,
`endif
  output logic                buf_WR,
  output logic                buf_RD,
  output logic [AW-1:0]       buf_addr,
  output logic                rd_valid,
  output logic [BITWIDTH-1:0] rd_data,
  output logic [AW:0]         count,
  output logic                empty,
  output logic                full,
  output logic                overrun,
  output logic                irq
);

  typedef enum logic {IDLE, RD_DATA} state_e;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, empty_q;
  logic          overrun_q, overrun_d;
  logic          do_wr, do_rd, drop;

  // Writes win over reads; the read is retried because rd_req is a level.
  // NOTE: every signal assigned here gets a default first, so no latches are inferred.
  always_comb begin
    do_wr     = 1'b0;
    do_rd     = 1'b0;
    drop      = 1'b0;
    state_d   = IDLE;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;

    if (!Rst) begin
      do_wr = rx_valid && !full_q;
      drop  = rx_valid && full_q;
      do_rd = (state_q == IDLE) && !do_wr && rd_req && !empty_q;
    end

    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      count_d  = count_q + (AW+1)'(1);
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      count_d  = count_q - (AW+1)'(1);
      state_d  = RD_DATA;
    end

    if (drop)         overrun_d = 1'b1;
    else if (ovr_clr) overrun_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= (count_d == FULL_CNT);
      empty_q   <= (count_d == '0);
      overrun_q <= overrun_d;
    end
  end

`ifdef RXC_THRESH_EN
  logic irq_q;

  always_ff @(posedge Clk) begin
    if (Rst) irq_q <= 1'b0;
    else     irq_q <= (thresh != '0) && (count_d >= thresh);
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  assign buf_WR   = do_wr;
  assign buf_RD   = do_rd;
  assign buf_addr = do_wr ? wr_ptr_q : rd_ptr_q;
  assign rd_valid = (state_q == RD_DATA);
  assign rd_data  = rd_valid ? buf_dout : '0;
  assign count    = count_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_rx_buffer_ctrl.sv
// Scoreboard bench for rx_buffer_ctrl: queue-based reference model, directed and random stimulus.
// Define RXC_THRESH_EN to exercise the threshold interrupt.
module tb_rx_buffer_ctrl;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int BW    = 8;

  logic          Clk = 1'b0;
  logic          Rst, rx_valid, rd_req, ovr_clr;
  logic [BW-1:0] buf_dout;
  logic          buf_WR, buf_RD, rd_valid, empty, full, overrun, irq;
  logic [AW-1:0] buf_addr;
  logic [BW-1:0] rd_data;
  logic [AW:0]   count;
`ifdef RXC_THRESH_EN
  logic [AW:0]   thresh = 3'd3;
`endif

  rx_buffer_ctrl #(.DEPTH(DEPTH), .AW(AW), .BITWIDTH(BW)) dut (
    .Clk(Clk), .Rst(Rst), .rx_valid(rx_valid), .rd_req(rd_req), .ovr_clr(ovr_clr),
    .buf_dout(buf_dout),
`ifdef RXC_THRESH_EN
    .thresh(thresh),
`endif
    .buf_WR(buf_WR), .buf_RD(buf_RD), .buf_addr(buf_addr), .rd_valid(rd_valid),
    .rd_data(rd_data), .count(count), .empty(empty), .full(full), .overrun(overrun),
    .irq(irq)
  );

  always #5 Clk = ~Clk;

  // Buffer RAM with registered read port, written with the byte presented alongside rx_valid.
  logic [BW-1:0] mem [DEPTH];
  logic [BW-1:0] rx_byte;
  always @(posedge Clk) begin
    if (buf_WR) mem[buf_addr] <= rx_byte;
    if (buf_RD) buf_dout <= mem[buf_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of stored bytes plus running write/read totals.
  logic [BW-1:0] mq [$];
  logic [BW-1:0] rd_exp_q [$];
  int  wr_n = 0, rd_n = 0;
  bit  ovr = 0, reading = 0, mon_en = 0;

  task automatic cycle(bit rst, bit rx, logic [BW-1:0] b, bit rd, bit clr);
    bit ew, er;
    int exp_addr;
    @(negedge Clk);
    check("count", count, mq.size());
    check("empty", empty, mq.size() == 0);
    check("full", full, mq.size() == DEPTH);
    check("overrun", overrun, ovr);
    check("rd_valid", rd_valid, reading);
`ifdef RXC_THRESH_EN
    check("irq", irq, (thresh != 0) && (mq.size() >= int'(thresh)));
`else
    check("irq", irq, 0);
`endif
    Rst = rst; rx_valid = rx; rx_byte = b; rd_req = rd; ovr_clr = clr;
    #1;
    ew = !rst && rx && (mq.size() < DEPTH);
    er = !rst && !reading && !ew && rd && (mq.size() > 0);
    exp_addr = ew ? (wr_n % DEPTH) : (rd_n % DEPTH);
    check("buf_WR", buf_WR, ew);
    check("buf_RD", buf_RD, er);
    check("buf_addr", buf_addr, exp_addr);
    if (rst) begin
      mq.delete();
      wr_n = 0; rd_n = 0; ovr = 0; reading = 0;
    end else begin
      if (rx && !ew) ovr = 1;
      else if (clr)  ovr = 0;
      if (ew) begin mq.push_back(b); wr_n++; end
      if (er) begin rd_exp_q.push_back(mq.pop_front()); rd_n++; end
      reading = er;
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents read data.
  initial begin
    wait (mon_en);
    forever begin
      @(negedge Clk);
      #2;
      check("strobe_mutex", buf_WR & buf_RD, 0);
      if (rd_valid) begin
        if (rd_exp_q.size() == 0) check("rd_unexpected", rd_data, 32'hdead);
        else check("rd_data", rd_data, rd_exp_q.pop_front());
      end else begin
        check("rd_data_idle", rd_data, 0);
      end
    end
  end

  initial begin
    Rst = 1'b1; rx_valid = 1'b0; rd_req = 1'b0; ovr_clr = 1'b0; rx_byte = '0;
    repeat (2) @(posedge Clk);
    mon_en = 1;

    // Fill with 11..44, then read back holding rd_req.
    for (int i = 0; i < 4; i++) cycle(0, 1, 8'(8'h11 * (i + 1)), 0, 0);
    repeat (8) cycle(0, 0, 8'h00, 1, 0);
    cycle(0, 0, 8'h00, 0, 0);

    // Overrun while full, then clear.
    for (int i = 0; i < 4; i++) cycle(0, 1, 8'(8'ha0 + i), 0, 0);
    cycle(0, 1, 8'hee, 0, 0);
    cycle(0, 0, 8'h00, 0, 0);
    cycle(0, 1, 8'hef, 0, 1);
    cycle(0, 0, 8'h00, 0, 1);
    repeat (9) cycle(0, 0, 8'h00, 1, 0);

    // Collision at count 1.
    cycle(0, 1, 8'h5a, 0, 0);
    cycle(0, 1, 8'h5b, 1, 0);
    cycle(0, 0, 8'h00, 1, 0);
    cycle(0, 0, 8'h00, 0, 0);
    repeat (3) cycle(0, 0, 8'h00, 1, 0);

    // Read on empty waits for a write, then reset while in RD_DATA.
    repeat (3) cycle(0, 0, 8'h00, 1, 0);
    cycle(0, 1, 8'h77, 1, 0);
    cycle(0, 0, 8'h00, 1, 0);
    cycle(1, 1, 8'h88, 0, 0);
    cycle(0, 0, 8'h00, 0, 0);

    // Random traffic with occasional clears and resets.
    for (int i = 0; i < 800; i++)
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, 8'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);

    repeat (3) cycle(0, 0, 8'h00, 0, 0);
    check("scoreboard_drained", rd_exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rx_buffer_ctrl.md
# rx_buffer_ctrl

Sequencing controller for the UART receive path's 4-entry receive buffer. It owns the write and read pointers, the occupancy count and the full/empty/overrun status. It serialises receiver writes and host reads onto the buffer's single address port, because the buffer performs no operation when write and read are both asserted. It also qualifies the buffer's registered read data for the host with a one-cycle valid strobe.

## Interface
Parameters:
- `DEPTH`, default 4: number of buffer entries. Must be a power of two.
- `AW`, default 2: address width, equal to log2(`DEPTH`).
- `BITWIDTH`, default 8: width of one data word.

Ports:
- `Clk`, input, 1 bit: clock. All logic is on the rising edge.
- `Rst`, input, 1 bit: reset. Synchronous, active-high.
- `rx_valid`, input, 1 bit: one-cycle pulse from the receiver meaning "byte ready to store".
- `rd_req`, input, 1 bit: host read request, level-sensitive.
- `ovr_clr`, input, 1 bit: clears the sticky overrun flag.
- `buf_dout`, input, `BITWIDTH` bits: buffer data output.
- `buf_WR`, output, 1 bit: buffer write strobe.
- `buf_RD`, output, 1 bit: buffer read strobe.
- `buf_addr`, output, `AW` bits: buffer address.
- `rd_valid`, output, 1 bit: `rd_data` is valid this cycle.
- `rd_data`, output, `BITWIDTH` bits: equals `buf_dout` when `rd_valid` is 1, otherwise 0.
- `count`, output, `AW+1` bits: buffer occupancy.
- `empty`, output, 1 bit: high when `count` is 0.
- `full`, output, 1 bit: high when `count` equals `DEPTH`.
- `overrun`, output, 1 bit: sticky flag set when a byte is dropped.
- `irq`, output, 1 bit: threshold interrupt (see Configuration).
- `thresh`, input, `AW+1` bits: interrupt threshold. Present only when `RXC_THRESH_EN` is defined.

## Operation
- **State register:** two states, `IDLE` and `RD_DATA`.
- **Pointers:** `wr_ptr` and `rd_ptr` are each `AW` bits wide and wrap modulo `DEPTH`. `count` is maintained separately, so full and empty are never ambiguous.
- **IDLE, priority 1 (write):** if `rx_valid` is high and `full` is low:
  - assert `buf_WR`, with `buf_addr` set to `wr_ptr`;
  - increment `wr_ptr` and `count`;
  - stay in `IDLE`.
- **IDLE, priority 2 (read):** otherwise, if `rd_req` is high and `empty` is low:
  - assert `buf_RD`, with `buf_addr` set to `rd_ptr`;
  - increment `rd_ptr` and decrement `count`;
  - go to `RD_DATA`.
- **Simultaneous `rx_valid` and `rd_req`:** the write wins. The read is not lost, because `rd_req` is a level and is serviced in the next free cycle.
- **RD_DATA:**
  - `rd_valid` is 1, and `rd_data` carries `buf_dout` as registered by the previous `buf_RD` edge.
  - `rd_req` is ignored in this state.
  - A concurrent `rx_valid` with `full` low is still written (`buf_WR`, `wr_ptr`). The write does not disturb `buf_dout` until after this cycle.
  - Always returns to `IDLE` on the next edge.
- **Full:** `rx_valid` while `full` is high raises no `buf_WR`. The byte is dropped and `overrun` is set to 1 on the next edge. `overrun` holds until `ovr_clr` is high or `Rst` is high. If set and clear happen in the same cycle, set wins.
- **Empty:** `rd_req` while `empty` is high raises no `buf_RD`. The request waits until a write lands.
- **Host handshake:** the host holds `rd_req` until it sees `rd_valid`. It drops `rd_req` in the cycle after `rd_valid`, or keeps it high to request the next byte.
- **Mutual exclusion:** `buf_WR` and `buf_RD` are never both high.
- **Idle address:** when neither strobe is high, `buf_addr` equals `rd_ptr`.

## Timing
- **Reset values:**
  - state `IDLE`; `wr_ptr` and `rd_ptr` 0; `count` 0;
  - `empty` 1; `full` 0; `overrun` 0; `irq` 0;
  - `rd_valid` 0; `rd_data` 0; `buf_WR` and `buf_RD` 0.
- **Reset mid-operation:** stored bytes are discarded.
  - `Rst` high in `RD_DATA`: `rd_valid` is 0 from the next cycle.
  - A `rx_valid` arriving in the same cycle as `Rst` is dropped and does not set `overrun`.
- **Output timing:**
  - `buf_WR`, `buf_RD` and `buf_addr` are combinational from state, inputs, pointers and count.
  - `count`, `empty`, `full` and `overrun` are registered.
- **Read latency:**
  - cycle N: `rd_req` sampled with `buf_RD` high;
  - cycle N+1: `rd_valid` is 1.
  - Maximum read throughput is one byte per two cycles.
- **Write throughput:** one byte per cycle when not full. `count` updates on the edge that ends the `buf_WR` cycle.

## Configuration
- **`RXC_THRESH_EN` defined:**
  - the `thresh` port exists;
  - `irq` is a registered output equal to 1 when `thresh` is non-zero and `count` is at least `thresh`.
- **`RXC_THRESH_EN` not defined:** the `thresh` port is absent and `irq` is tied to 0.

## Test plan
- **Reset:** hold `Rst` for 2 cycles. Expect `count` 0, `empty` 1, `full` 0, `overrun` 0, `rd_valid` 0, and no strobes.
- **Fill, then read in order:** pulse `rx_valid` 4 times with `buf_dout` model bytes 0x11, 0x22, 0x33, 0x44. Expect:
  - `buf_addr` 0, 1, 2, 3 on the writes;
  - `full` 1 afterwards;
  - four reads return 0x11, 0x22, 0x33, 0x44, each with `rd_valid` exactly 1 cycle after `buf_RD`;
  - `empty` 1 at the end.
- **Overrun:** with `full` high, pulse `rx_valid`. Expect no `buf_WR`, `overrun` 1, `count` still 4. Then pulse `ovr_clr`: expect `overrun` 0.
- **Collision:** with `count` 1, assert `rx_valid` and `rd_req` in the same cycle. Expect:
  - `buf_WR` in that cycle and `buf_RD` in the next;
  - `count` goes 1, then 2, then 1;
  - `buf_WR` and `buf_RD` never high together.
- **Read on empty and reset in RD_DATA:**
  - `rd_req` with `count` 0: no `buf_RD` until a `rx_valid` arrives; then `buf_RD` one cycle later.
  - `Rst` high in `RD_DATA`: `rd_valid` 0 and `count` 0 the next cycle.
- **Threshold (`RXC_THRESH_EN`):** with `thresh` 3, `irq` rises on the edge where `count` reaches 3. After one read, `irq` falls.
